// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 DIT FFT stage sequencer: sizes, FSM state
// encoding and the butterfly address generator used by the sequencer.
package fft_pkg;

  localparam int LOG2N = 4;
  localparam int N     = 2**LOG2N;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic [LOG2N-1:0] a;
    logic [LOG2N-1:0] b;
    logic [LOG2N-2:0] tw;
  } bfly_addr_t;

  // Stage s, butterfly k: operands are span apart inside groups of 2*span.
  function automatic bfly_addr_t addr_gen(input int unsigned s, input int unsigned k);
    bfly_addr_t  r;
    int unsigned span;
    int unsigned pos;
    int unsigned a;
    span = 32'd1 << s;
    pos  = k & (span - 32'd1);
    a    = ((k >> s) << (s + 32'd1)) + pos;
    r.a  = LOG2N'(a);
    r.b  = LOG2N'(a + span);
    r.tw = (LOG2N-1)'(pos << (LOG2N - 1 - s));
    return r;
  endfunction

endpackage

// File: rtl/fft_addr_delay.sv
// LAT-deep shift register of {valid, addr_a, addr_b}; turns read issues into
// write-back strobes. Synchronous reset flushes every slot.
module fft_addr_delay #(
  parameter int LAT = 3,
  parameter int AW  = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  input  logic [AW-1:0] i_addr_a,
  input  logic [AW-1:0] i_addr_b,
  output logic          o_valid,
  output logic [AW-1:0] o_addr_a,
  output logic [AW-1:0] o_addr_b
);

  logic [LAT-1:0] v_q;
  logic [AW-1:0]  a_q [LAT];
  logic [AW-1:0]  b_q [LAT];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < LAT; i++) begin
        v_q[i] <= 1'b0;
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else begin
      v_q[0] <= i_valid;
      a_q[0] <= i_addr_a;
      b_q[0] <= i_addr_b;
      for (int i = 1; i < LAT; i++) begin
        v_q[i] <= v_q[i-1];
        a_q[i] <= a_q[i-1];
        b_q[i] <= b_q[i-1];
      end
    end
  end

  assign o_valid  = v_q[LAT-1];
  assign o_addr_a = a_q[LAT-1];
  assign o_addr_b = b_q[LAT-1];

endmodule

// File: rtl/fft_stage_sequencer.sv
// Radix-2 DIT FFT stage sequencer: one butterfly issue per cycle, drain between
// stages, delayed write-back. Optional issue stall with FFT_SEQ_STALL_EN.
module fft_stage_sequencer #(
  parameter int LOG2N    = fft_pkg::LOG2N,
  parameter int BFLY_LAT = 3
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
`ifdef FFT_SEQ_STALL_EN
  input  logic                     i_stall,
`endif
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_rd_en,
  output logic [LOG2N-1:0]         o_rd_addr_a,
  output logic [LOG2N-1:0]         o_rd_addr_b,
  output logic [LOG2N-2:0]         o_tw_idx,
  output logic [$clog2(LOG2N)-1:0] o_stage,
  output logic                     o_wr_en,
  output logic [LOG2N-1:0]         o_wr_addr_a,
  output logic [LOG2N-1:0]         o_wr_addr_b
);

  import fft_pkg::*;

  localparam int KW = LOG2N - 1;
  localparam int SW = $clog2(LOG2N);
  localparam logic [KW-1:0] LAST_K     = '1;
  localparam logic [SW-1:0] LAST_STAGE = SW'(LOG2N - 1);
  localparam logic [3:0]    LAST_DRAIN = 4'(BFLY_LAT - 1);

  seq_state_t    state, state_next;
  logic [KW-1:0] k, k_next;
  logic [SW-1:0] stage, stage_next;
  logic [3:0]    cnt, cnt_next;
  logic          stall;
  logic          issue;
  bfly_addr_t    ag;

`ifdef FFT_SEQ_STALL_EN
  assign stall = i_stall;
`else
  assign stall = 1'b0;
`endif

  assign issue = (state == RUN) && !stall;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      k     <= '0;
      stage <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      k     <= k_next;
      stage <= stage_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    k_next     = k;
    stage_next = stage;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (i_start) begin
          state_next = RUN;
          k_next     = '0;
          stage_next = '0;
        end
      end
      RUN: begin
        if (issue) begin
          if (k == LAST_K) begin
            state_next = DRAIN;
            cnt_next   = '0;
          end else begin
            k_next = k + 1'b1;
          end
        end
      end
      DRAIN: begin
        // The stage's last write must land before the next stage reads it.
        if (cnt == LAST_DRAIN) begin
          if (stage == LAST_STAGE) begin
            state_next = DONE;
          end else begin
            state_next = RUN;
            stage_next = stage + 1'b1;
            k_next     = '0;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb ag = addr_gen(32'(stage), 32'(k));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_rd_en     <= 1'b0;
      o_rd_addr_a <= '0;
      o_rd_addr_b <= '0;
      o_tw_idx    <= '0;
      o_stage     <= '0;
    end else begin
      o_busy      <= (state == RUN) || (state == DRAIN);
      o_done      <= (state == DONE);
      o_rd_en     <= issue;
      o_rd_addr_a <= issue ? ag.a  : '0;
      o_rd_addr_b <= issue ? ag.b  : '0;
      o_tw_idx    <= issue ? ag.tw : '0;
      o_stage     <= ((state == RUN) || (state == DRAIN)) ? stage : '0;
    end
  end

  fft_addr_delay #(
    .LAT (BFLY_LAT),
    .AW  (LOG2N)
  ) u_delay (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_valid  (o_rd_en),
    .i_addr_a (o_rd_addr_a),
    .i_addr_b (o_rd_addr_b),
    .o_valid  (o_wr_en),
    .o_addr_a (o_wr_addr_a),
    .o_addr_b (o_wr_addr_b)
  );

endmodule

// File: doc/fft_stage_sequencer.md
# fft_stage_sequencer

Run-time sequencer for the in-place radix-2 DIT FFT datapath (default 16 points, 4 stages). After a start pulse it walks all stages and issues one butterfly per cycle: read address pair, twiddle index and stage number. It delays each issued address pair by the butterfly latency to produce the write-back strobe, and drains the pipeline between stages. It sits between the top-level FFT control and the sample RAM / butterfly / twiddle ROM.

## Interface
- LOG2N, 4, log2 of FFT size; N = 2**LOG2N points, LOG2N stages, N/2 butterflies per stage
- BFLY_LAT, 3, butterfly datapath latency in cycles from read issue to write-back; legal range 1..8
- i_clk  in  1  sole clock, rising edge
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  start request; sampled only in IDLE
- i_stall  in  1  issue hold; present only with FFT_SEQ_STALL_EN
- o_busy  out  1  high from the first issue cycle through the last write-back cycle
- o_done  out  1  one-cycle pulse after the final write-back
- o_rd_en  out  1  butterfly issue strobe
- o_rd_addr_a / o_rd_addr_b  out  LOG2N each  butterfly operand addresses
- o_tw_idx  out  LOG2N-1  twiddle ROM index
- o_stage  out  $clog2(LOG2N)  current stage, 0..LOG2N-1
- o_wr_en  out  1  write-back strobe; equals o_rd_en delayed BFLY_LAT cycles
- o_wr_addr_a / o_wr_addr_b  out  LOG2N each  write-back addresses; equal the read addresses delayed BFLY_LAT cycles

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: i_start=1 moves the FSM to RUN with stage=0 and k=0. While IDLE, nothing else happens.
- RUN: each cycle issue butterfly k of the current stage, then increment k. After k=N/2-1 has been issued, go to DRAIN.
- DRAIN: hold for BFLY_LAT cycles so the stage's last writes land before the next stage reads (RAW hazard). At the end of the hold:
  - if stage < LOG2N-1: increment stage, set k=0, go to RUN;
  - otherwise: go to DONE.
- DONE: o_done=1 for one cycle, then IDLE.
- Address rules for stage s, butterfly k:
  - span = 2**s
  - pos = k mod span
  - grp = k >> s
  - a = grp·2·span + pos
  - b = a + span
  - tw = pos << (LOG2N-1-s)
- The input is already in bit-reversed order; reordering is the loader's job, not this block's.
- When o_rd_en=0, the read addresses and o_tw_idx are driven to 0. When o_wr_en=0, the write addresses are driven to 0.
- i_start outside IDLE is ignored and is not queued.
- Reset, including mid-run:
  - next cycle all outputs are 0;
  - delay line is flushed, so there are no stray o_wr_en pulses;
  - state returns to IDLE.

## Timing
- All outputs are registered.
- Start is sampled at edge 0. Stage s issues at cycles 1+s·(N/2+BFLY_LAT) through N/2+s·(N/2+BFLY_LAT). Writes follow BFLY_LAT cycles after each issue.
- Defaults:
  - per-stage period is 11 cycles;
  - o_rd_en high in cycles 1–8, 12–19, 23–30, 34–41;
  - o_wr_en high in cycles 4–11, …, 37–44;
  - o_busy high in cycles 1–44;
  - o_done high in cycle 45;
  - IDLE in cycle 46, when a new start is accepted.
- o_busy=0 during DONE.
- o_stage is valid while o_rd_en=1 and holds its value through that stage's DRAIN.

## Configuration
- FFT_SEQ_STALL_EN defined:
  - i_stall exists;
  - i_stall=1 in RUN holds k, forces o_rd_en=0 and adds no issue;
  - in-flight writes keep draining; DRAIN and DONE ignore i_stall.
- FFT_SEQ_STALL_EN undefined: the port is absent and issue never pauses.

## Structure
- Shared package fft_pkg holds:
  - LOG2N and N constants;
  - the sequencer state enum typedef;
  - an address-generation function (s, k) -> {a, b, tw], shared with the verification model.
- Sub-module fft_addr_delay: a BFLY_LAT-deep shift register of {valid, addr_a, addr_b}, cleared by i_rst.

## Test plan
- Reset, then one start pulse with defaults:
  - 32 issues in total;
  - o_done exactly in cycle 45;
  - o_busy high for exactly 44 cycles.
- Address spot checks:
  - stage 0, k=3 -> a=6, b=7, tw=0;
  - stage 1, k=5 -> a=9, b=11, tw=4;
  - stage 2, k=6 -> a=10, b=14, tw=4;
  - stage 3, k=7 -> a=7, b=15, tw=7.
- Pipeline relation: across the whole run, every o_wr_en/o_wr_addr sample equals o_rd_en/o_rd_addr from 3 cycles earlier. No read of stage s+1 precedes the last write of stage s.
- i_start held high through the whole run: exactly one run occurs. A second run starts only when start is sampled in cycle 46 (IDLE).
- i_rst in cycle 20 (mid stage 1):
  - cycle 21 has all outputs 0;
  - no o_wr_en pulse afterwards;
  - a fresh start reproduces the nominal timeline.
- FFT_SEQ_STALL_EN with i_stall high for cycles 3–5:
  - stage 0 issues in cycles 1–2 and 6–11 with k continuing at 2;
  - o_done moves to cycle 48.
